// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
//
// Receive-side UART deframer. Oversamples the serial line, detects the start
// bit, and recovers DATAWIDTH data bits LSB-first. An optional parity bit and
// one stop bit follow. Each bit value is the majority vote of three samples
// taken around the bit centre. A good frame updates P_DATA and pulses
// data_Valid. Parity and stop-bit problems are flagged with one-cycle pulses
// instead, and P_DATA keeps its previous value.
//
// Optional build macro:
//   UART_RX_SYNC_EN - when defined, RX_IN passes through a 2-flop synchronizer
//                     (both flops reset to 1) and all timing shifts by +2 clk.
//                     When undefined, RX_IN must already be synchronous to clk.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   RX_IN      in   serial line, idle high
//   PAR_EN     in   1 = frame carries a parity bit (latched at frame start)
//   PAR_TYP    in   0 = even, 1 = odd parity (latched at frame start)
//   P_DATA     out  last correctly received word
//   data_Valid out  one-cycle pulse when P_DATA is updated
//   par_err    out  one-cycle pulse on parity mismatch
//   stp_err    out  one-cycle pulse when the stop bit is sampled low
//   busy       out  high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx_deframer #(
    parameter int DATAWIDTH  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int CNTW       = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX_IN,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    output logic [DATAWIDTH-1:0] P_DATA,
    output logic                 data_Valid,
    output logic                 par_err,
    output logic                 stp_err,
    output logic                 busy
);

    localparam int M   = OVERSAMPLE / 2;
    localparam int BCW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

    localparam logic [CNTW-1:0] TICK_LAST = CNTW'(OVERSAMPLE - 1);
    localparam logic [CNTW-1:0] TICK_S0   = CNTW'(M - 1);
    localparam logic [CNTW-1:0] TICK_S1   = CNTW'(M);
    localparam logic [CNTW-1:0] TICK_VOTE = CNTW'(M + 1);
    localparam logic [BCW-1:0]  BIT_LAST  = BCW'(DATAWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic                 rx;
    logic [CNTW-1:0]      tick_reg;
    logic [BCW-1:0]       bit_cnt_reg;
    logic [DATAWIDTH-1:0] shift_reg;
    logic                 samp0_reg, samp1_reg;
    logic                 par_bit_reg;
    logic                 frame_par_en_reg, frame_par_typ_reg;

    logic                 tick_end, vote_tick, last_bit, voted, par_exp;
    logic                 valid_next, par_err_next, stp_err_next;

    // -------------------------------------------------------------------------
    // Line input, optionally synchronized
    // -------------------------------------------------------------------------
`ifdef UART_RX_SYNC_EN
    logic rx_meta_reg, rx_sync_reg;

    // Both flops reset high so the idle line is not mistaken for a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= RX_IN;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    assign rx = rx_sync_reg;
`else
    assign rx = RX_IN;
`endif

    // -------------------------------------------------------------------------
    // Shared decode
    // -------------------------------------------------------------------------
    assign tick_end  = (tick_reg == TICK_LAST);
    assign vote_tick = (tick_reg == TICK_VOTE);
    assign last_bit  = (bit_cnt_reg == BIT_LAST);

    // The third sample is the live line value at tick M+1, so the vote
    // resolves in the same cycle as that sample.
    assign voted = (samp0_reg & samp1_reg) | (samp0_reg & rx) | (samp1_reg & rx);

    // Even parity expects the XOR of the data bits; odd parity expects its inverse.
    assign par_exp = (^shift_reg) ^ frame_par_typ_reg;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!rx) begin
                    state_next = START;
                end
            end
            START: begin
                // A start bit that votes high was a glitch; drop it quietly.
                if (vote_tick && voted) begin
                    state_next = IDLE;
                end else if (tick_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick_end && last_bit) begin
                    state_next = frame_par_en_reg ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leave at the decision tick, not at the end of the stop bit.
                // This lets a back-to-back start bit be caught on time.
                if (vote_tick) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output logic (values registered into the strobes below)
    // -------------------------------------------------------------------------
    always_comb begin
        valid_next   = 1'b0;
        par_err_next = 1'b0;
        stp_err_next = 1'b0;
        if (state_reg == STOP && vote_tick) begin
            stp_err_next = ~voted;
            par_err_next = frame_par_en_reg & (par_bit_reg != par_exp);
            valid_next   = voted & ~(frame_par_en_reg & (par_bit_reg != par_exp));
        end
    end

    assign busy = (state_reg != IDLE);

    // -------------------------------------------------------------------------
    // Datapath: counters, sampling, shift register, frame settings
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_reg          <= '0;
            bit_cnt_reg       <= '0;
            shift_reg         <= '0;
            samp0_reg         <= 1'b1;
            samp1_reg         <= 1'b1;
            par_bit_reg       <= 1'b0;
            frame_par_en_reg  <= 1'b0;
            frame_par_typ_reg <= 1'b0;
        end else if (state_reg == IDLE) begin
            // Counters are held clear in IDLE, so they start at 0 on the
            // first cycle of START.
            tick_reg    <= '0;
            bit_cnt_reg <= '0;
            if (!rx) begin
                frame_par_en_reg  <= PAR_EN;
                frame_par_typ_reg <= PAR_TYP;
            end
        end else begin
            tick_reg <= tick_end ? '0 : tick_reg + CNTW'(1);

            if (tick_reg == TICK_S0) begin
                samp0_reg <= rx;
            end
            if (tick_reg == TICK_S1) begin
                samp1_reg <= rx;
            end

            if (state_reg == DATA) begin
                if (vote_tick) begin
                    shift_reg[bit_cnt_reg] <= voted;
                end
                if (tick_end) begin
                    bit_cnt_reg <= bit_cnt_reg + BCW'(1);
                end
            end

            if (state_reg == PARITY && vote_tick) begin
                par_bit_reg <= voted;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            P_DATA     <= '0;
            data_Valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_Valid <= valid_next;
            par_err    <= par_err_next;
            stp_err    <= stp_err_next;
            if (valid_next) begin
                P_DATA <= shift_reg;
            end
        end
    end

endmodule
